// File: rtl/kara_pkg.sv
// Shared definitions for the kara_div long divider: default operand width,
// FSM state encoding and the iteration counter width.
package kara_pkg;

    localparam int KARA_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } kara_state_t;

    // One extra bit so the counter can hold the full iteration count W.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int KARA_CNT_W = cnt_width(KARA_W);

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: compare the shifted partial remainder with the
// divisor and subtract when it fits. Purely combinational.
module div_step #(
    parameter int W = 256
) (
    input  logic [W:0]   t,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    // The partial remainder stays below the divisor, so T < 2*divisor and
    // T - divisor always fits back into W bits when the subtract is taken.
    always_comb begin
        q_bit  = (t >= {1'b0, divisor});
        r_next = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];
    end

endmodule

// File: rtl/kara_div.sv
// Unsigned 2W/W restoring divider. Divide-by-zero and quotient overflow are
// detected at accept time and finish in one edge; otherwise W iterations run.
//
// state | meaning
// IDLE  | waiting for start; results and flags held
// RUN   | one quotient bit per edge, counter counting down from W
// FIN   | publish results, pulse done, drop busy
module kara_div
    import kara_pkg::*;
#(
    parameter int W = KARA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = cnt_width(W);

    kara_state_t    state;
    kara_state_t    state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   r_q;
    logic [W-1:0]   q_q;
    logic [W-1:0]   dvs_q;

    logic [W-1:0]   dvd_hi;
    logic [W-1:0]   dvd_lo;
    logic           div_zero;
    logic           quo_ovf;
    logic           accept;

    logic [W:0]     step_t;
    logic [W-1:0]   step_r;
    logic           step_q;

    assign dvd_hi   = dividend[2*W-1:W];
    assign dvd_lo   = dividend[W-1:0];
    assign div_zero = (divisor == '0);
    // Quotient would need more than W bits; meaningless when dividing by zero.
    assign quo_ovf  = !div_zero && (dvd_hi >= divisor);
    assign accept   = (state == IDLE) && start;

    assign step_t   = {r_q, q_q[W-1]};

    div_step #(.W(W)) u_step (
        .t       (step_t),
        .divisor (dvs_q),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: special cases skip straight to FIN; RUN ends on the last count.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (div_zero || quo_ovf) ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        dvs_q <= divisor;
                        dbz   <= div_zero;
                        ovf   <= quo_ovf;
                        if (div_zero || quo_ovf) begin
                            r_q <= '0;
                            q_q <= '1;
                            cnt <= '0;
                        end else begin
                            r_q <= dvd_hi;
                            q_q <= dvd_lo;
                            cnt <= CW'(W);
                        end
                    end
                end
                RUN: begin
                    r_q <= step_r;
                    q_q <= {q_q[W-2:0], step_q};
                    cnt <= cnt - CW'(1);
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    quotient  <= q_q;
                    remainder <= r_q;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kara_div.sv
// Directed bench for kara_div with an arithmetic reference model and a
// per-cycle compare process.
module tb_kara_div;

    localparam int W = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2*W-1:0]   dividend = '0;
    logic [W-1:0]     divisor = '0;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acc = 0;

    kara_div #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: results from plain division, timing from the
    // accept-to-done latency (1 edge for special cases, W+1 otherwise).
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    int             m_left = 0;
    logic [W-1:0]   m_q = '0;
    logic [W-1:0]   m_r = '0;
    logic           m_dbz = 1'b0;
    logic           m_ovf = 1'b0;
    logic [W-1:0]   p_q = '0;
    logic [W-1:0]   p_r = '0;
    logic           p_dbz = 1'b0;
    logic           p_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [2*W-1:0] dvs_ext;
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy  <= 1'b1;
                dvs_ext = {{W{1'b0}}, divisor};
                if (divisor == '0) begin
                    p_q <= '1; p_r <= '0; p_dbz <= 1'b1; p_ovf <= 1'b0; m_left <= 1;
                end else if (dividend / dvs_ext >= (2*W)'(1) << W) begin
                    p_q <= '1; p_r <= '0; p_dbz <= 1'b0; p_ovf <= 1'b1; m_left <= 1;
                end else begin
                    p_q   <= W'(dividend / dvs_ext);
                    p_r   <= W'(dividend % dvs_ext);
                    p_dbz <= 1'b0;
                    p_ovf <= 1'b0;
                    m_left <= W + 1;
                end
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_dbz  <= p_dbz;
                    m_ovf  <= p_ovf;
                end
            end
        end
    end

    // Compare every cycle: handshake always, results while not busy, flags with done.
    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        if (!m_busy) begin
            check("quotient_held", quotient, m_q);
            check("remainder_held", remainder, m_r);
        end
        if (m_done) begin
            check("dbz", dbz, m_dbz);
            check("ovf", ovf, m_ovf);
        end
    end

    // Called at a negedge: presents start for one cycle and records the accept edge.
    task automatic do_start(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(negedge clk);
        start = 1'b0;
        n_acc = cyc;
    endtask

    task automatic wait_done(output int lat);
        int k;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", done, 1'b1);
        lat = cyc - n_acc;
    endtask

    logic [2*W-1:0] big;
    logic [W-1:0]   ones;
    logic [2*W-1:0] rd;
    logic [W-1:0]   rs;
    int lat;
    int n_d;

    initial begin
        ones = '1;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_ovf", ovf, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7
        do_start(100, 7);
        wait_done(lat);
        check("lat_100_7", lat, W + 1);
        check("q_100_7", quotient, 14);
        check("r_100_7", remainder, 2);
        check("dbz_100_7", dbz, 0);
        check("ovf_100_7", ovf, 0);
        @(negedge clk);

        // (2^W-1)^2 / (2^W-1)
        big = {{W{1'b0}}, ones} * {{W{1'b0}}, ones};
        do_start(big, ones);
        wait_done(lat);
        check("q_max", quotient, {{W{1'b0}}, ones});
        check("r_max", remainder, 0);
        check("flags_max", {dbz, ovf}, 0);
        @(negedge clk);

        // divide by zero
        do_start(12345, 0);
        wait_done(lat);
        check("lat_dbz", lat, 1);
        check("dbz_flag", dbz, 1);
        check("ovf_dbz", ovf, 0);
        check("q_dbz", quotient, {{W{1'b0}}, ones});
        check("r_dbz", remainder, 0);
        @(negedge clk);

        // 2^W / 1 overflows
        big = '0;
        big[W] = 1'b1;
        do_start(big, 1);
        wait_done(lat);
        check("lat_ovf", lat, 1);
        check("ovf_flag", ovf, 1);
        check("dbz_ovf", dbz, 0);
        @(negedge clk);

        // Busy start ignored; start in done cycle accepted
        do_start(100, 7);
        repeat (49) @(negedge clk);
        start = 1'b1; dividend = 1000; divisor = 3;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("lat_ignored", lat, W + 1);
        check("q_ignored", quotient, 14);
        check("r_ignored", remainder, 2);
        do_start(50, 5);
        wait_done(lat);
        check("lat_done_cycle", lat, W + 1);
        check("q_done_cycle", quotient, 10);
        check("r_done_cycle", remainder, 0);
        @(negedge clk);

        // Random normal-path operands, checked by identity as well as the model
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < W / 32; j++) begin
                rs[j*32 +: 32] = $urandom;
                rd[j*32 +: 32] = $urandom;
                rd[W + j*32 +: 32] = $urandom;
            end
            rs[W-1] = 1'b1;
            rd[2*W-1] = 1'b0;
            do_start(rd, rs);
            wait_done(lat);
            check("identity", {{W{1'b0}}, quotient} * {{W{1'b0}}, rs} + {{W{1'b0}}, remainder}, rd);
            check("rem_lt_div", remainder < rs, 1);
            @(negedge clk);
        end

        // Reset mid-run
        do_start(100, 7);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {quotient, remainder, busy, done, dbz, ovf}, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        n_d = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) n_d++;
        end
        check("midrst_no_done", n_d, 0);
        do_start(100, 7);
        wait_done(lat);
        check("lat_after_rst", lat, W + 1);
        check("q_after_rst", quotient, 14);
        check("r_after_rst", remainder, 2);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kara_div.md
KARA_DIV -- requirements
Module: kara_div

Interface
REQ-001 SHALL have parameter W, default 256, operand width; dividend is 2*W bits, divisor, quotient and remainder are W bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only while busy=0.
REQ-005 SHALL have port dividend  input  2*W  numerator, e.g. a product; sampled with start.
REQ-006 SHALL have port divisor  input  W  denominator; sampled with start.
REQ-007 SHALL have port quotient  output  W  result; held until the next accepted start.
REQ-008 SHALL have port remainder  output  W  result; held until the next accepted start.
REQ-009 SHALL have port busy  output  1  high from the accept edge until done is asserted.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag; valid with done, held afterwards.
REQ-012 SHALL have port ovf  output  1  quotient-overflow flag, set when dividend[2W-1:W] >= divisor; valid with done, held afterwards.

Function
REQ-013 SHALL implement states IDLE, RUN, FIN.
REQ-014 SHALL accept start only in IDLE (busy=0); start during RUN or FIN SHALL be ignored with no effect on the results.
REQ-015 Accept edge N, normal path: SHALL latch the operands, clear dbz and ovf, set busy, load partial remainder R=dividend[2W-1:W], load Q=dividend[W-1:0], and enter RUN with a W-count counter.
REQ-016 At the accept edge, if divisor==0, SHALL set dbz=1, ovf=0, quotient=all ones, remainder=0, and enter FIN.
REQ-017 At the accept edge, else if dividend[2W-1:W] >= divisor, SHALL set ovf=1, dbz=0, quotient=all ones, remainder=0, and enter FIN.
REQ-018 RUN, each edge: SHALL form T={R,Q[W-1]} (W+1 bits) and shift Q left by 1.
REQ-019 RUN, each edge: if T >= divisor, SHALL set R=T-divisor and Q[0]=1; else SHALL set R=T[W-1:0] and Q[0]=0 (restoring, radix 2).
REQ-020 SHALL leave RUN for FIN after exactly W iterations, at edges N+1..N+W; the counter SHALL not wrap.
REQ-021 In FIN, SHALL assert done=1 for exactly one cycle and drive quotient=Q and remainder=R, then return to IDLE.
REQ-022 Latency SHALL be W+1 edges from accept to done high (257 for W=256), or 1 edge on the dbz/ovf paths.
REQ-023 busy SHALL fall in the same cycle that done rises; a start presented during the done cycle SHALL be accepted.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor whenever dbz=ovf=0.
REQ-025 Dividend and divisor SHALL be treated as unsigned.

Reset
REQ-026 On rst_n low, SHALL asynchronously force state=IDLE, busy=0, done=0, dbz=0, ovf=0, quotient=0, remainder=0, and clear the counter.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-028 W, the state encoding, and the counter width ($clog2(W)+1) SHALL live in shared package kara_pkg.
REQ-029 The compare-and-subtract SHALL be one sub-module, div_step: a (W+1)-bit T and W-bit divisor in, a W-bit new R and a quotient bit out, purely combinational.

Verification
REQ-030 The bench SHALL cover: dividend=100, divisor=7 -> done at edge N+257, quotient=14, remainder=2, flags 0.
REQ-031 The bench SHALL cover: dividend=(2^256-1)*(2^256-1), divisor=2^256-1 -> quotient=2^256-1, remainder=0.
REQ-032 The bench SHALL cover: divisor=0 -> done at edge N+1, dbz=1, quotient=all ones, remainder=0.
REQ-033 The bench SHALL cover: dividend=2^256, divisor=1 -> ovf=1, done at edge N+1.
REQ-034 The bench SHALL cover: start re-pulsed at cycle N+50 with other operands -> ignored, first result unchanged; start in the done cycle -> accepted.
REQ-035 The bench SHALL cover: rst_n low at cycle N+100 -> all outputs 0 and no done pulse; a following 100/7 request -> 14 r 2.
